// File: rtl/vtg_mode_ctrl.sv
// vtg_mode_ctrl
//   Runtime video-mode controller for the sync generator. A staging copy of
//   every timing parameter is written through a small register port. A commit
//   request validates the staged set, waits for the next vertical-sync leading
//   edge (or a timeout), copies the set atomically into the active registers
//   and then holds the generator in reset for RST_HOLD cycles.
//
// Ports
//   I_pxl_clk        pixel clock, all logic on the rising edge
//   I_rst            synchronous active-high reset
//   I_cfg_wr/addr/wdata  staging register write port (IDLE only)
//                    addr 0..9 timing words, 10 = {vs_pol,hs_pol}, 11..15 no-op
//   I_commit         apply request (IDLE only)
//   I_vs             generator vertical sync, polarity per O_vs_pol
//   O_busy           high whenever the controller is not IDLE
//   O_done           one-cycle pulse when a new mode starts running
//   O_err            one-cycle pulse when the staged set is rejected
//   O_h_* / O_v_* / O_rd_*  active timing to the generator
//   O_hs_pol/O_vs_pol active sync polarities (1 = positive)
//   O_gen_rst_n      active-low reset to the generator
module vtg_mode_ctrl #(
    parameter int unsigned DEF_H_TOTAL  = 1650,
    parameter int unsigned DEF_H_SYNC   = 40,
    parameter int unsigned DEF_H_BPORCH = 220,
    parameter int unsigned DEF_H_RES    = 1280,
    parameter int unsigned DEF_V_TOTAL  = 750,
    parameter int unsigned DEF_V_SYNC   = 5,
    parameter int unsigned DEF_V_BPORCH = 20,
    parameter int unsigned DEF_V_RES    = 720,
    parameter int unsigned DEF_RD_HRES  = 1280,
    parameter int unsigned DEF_RD_VRES  = 720,
    parameter int unsigned DEF_HS_POL   = 1,
    parameter int unsigned DEF_VS_POL   = 1,
    parameter int unsigned RST_HOLD     = 4,
    parameter int unsigned VS_TMO       = 4194304
) (
    input  logic        I_pxl_clk,
    input  logic        I_rst,
    input  logic        I_cfg_wr,
    input  logic [3:0]  I_cfg_addr,
    input  logic [15:0] I_cfg_wdata,
    input  logic        I_commit,
    input  logic        I_vs,
    output logic        O_busy,
    output logic        O_done,
    output logic        O_err,
    output logic [15:0] O_h_total,
    output logic [15:0] O_h_sync,
    output logic [15:0] O_h_bporch,
    output logic [15:0] O_h_res,
    output logic [15:0] O_v_total,
    output logic [15:0] O_v_sync,
    output logic [15:0] O_v_bporch,
    output logic [15:0] O_v_res,
    output logic [15:0] O_rd_hres,
    output logic [15:0] O_rd_vres,
    output logic        O_hs_pol,
    output logic        O_vs_pol,
    output logic        O_gen_rst_n
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_WAIT_VS,
        ST_APPLY,
        ST_HOLD
    } state_t;

    localparam int unsigned NREG = 10;

    // Register file index order matches the write address map.
    localparam logic [15:0] DEF_REGS [NREG] = '{
        16'(DEF_H_TOTAL), 16'(DEF_H_SYNC), 16'(DEF_H_BPORCH), 16'(DEF_H_RES),
        16'(DEF_V_TOTAL), 16'(DEF_V_SYNC), 16'(DEF_V_BPORCH), 16'(DEF_V_RES),
        16'(DEF_RD_HRES), 16'(DEF_RD_VRES)
    };
    localparam logic [1:0] DEF_POL = {1'(DEF_VS_POL), 1'(DEF_HS_POL)};

    state_t      state_q, state_d;
    logic [31:0] hold_cnt_q, hold_cnt_d;
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
    logic [15:0] stg_q [NREG];
    logic [15:0] stg_d [NREG];
    logic [15:0] act_q [NREG];
    logic [15:0] act_d [NREG];
    logic [1:0]  stg_pol_q, stg_pol_d;
    logic [1:0]  act_pol_q, act_pol_d;
    logic        pend_done_q, pend_done_d;
    logic        gen_rst_n_q, gen_rst_n_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        s_q, s_d_q;

    logic        s_now;
    logic        vs_edge;
    logic [16:0] h_sum, v_sum;
    logic        cfg_ok;

    // Sync normalised to active-high, then registered twice: s_q is the
    // sampled level and s_d_q its previous value for leading-edge detection.
    assign s_now   = act_pol_q[1] ? I_vs : ~I_vs;
    assign vs_edge = s_q & ~s_d_q;

    assign h_sum = {1'b0, stg_q[1]} + {1'b0, stg_q[2]} + {1'b0, stg_q[3]};
    assign v_sum = {1'b0, stg_q[5]} + {1'b0, stg_q[6]} + {1'b0, stg_q[7]};

    always_comb begin
        cfg_ok = (stg_q[1] != '0) && (stg_q[3] != '0) &&
                 (stg_q[5] != '0) && (stg_q[7] != '0) &&
                 (h_sum <= {1'b0, stg_q[0]}) &&
                 (v_sum <= {1'b0, stg_q[4]}) &&
                 (stg_q[8] != '0) && (stg_q[8] <= stg_q[3]) &&
                 (stg_q[9] != '0) && (stg_q[9] <= stg_q[7]);
    end

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        stg_d       = stg_q;
        act_d       = act_q;
        stg_pol_d   = stg_pol_q;
        act_pol_d   = act_pol_q;
        pend_done_d = pend_done_q;
        gen_rst_n_d = 1'b1;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (I_cfg_wr) begin
                    for (int unsigned i = 0; i < NREG; i++) begin
                        if (I_cfg_addr == 4'(i)) begin
                            stg_d[i] = I_cfg_wdata;
                        end
                    end
                    if (I_cfg_addr == 4'd10) begin
                        stg_pol_d = I_cfg_wdata[1:0];
                    end
                end
                if (I_commit) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (cfg_ok) begin
                    state_d   = ST_WAIT_VS;
                    tmo_cnt_d = '0;
                end else begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end
            ST_WAIT_VS: begin
                tmo_cnt_d = tmo_cnt_q + 32'd1;
                if (vs_edge || (tmo_cnt_q == VS_TMO - 1)) begin
                    state_d = ST_APPLY;
                end
            end
            ST_APPLY: begin
                act_d       = stg_q;
                act_pol_d   = stg_pol_q;
                hold_cnt_d  = '0;
                pend_done_d = 1'b1;
                gen_rst_n_d = 1'b0;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                gen_rst_n_d = 1'b0;
                if (hold_cnt_q == RST_HOLD - 1) begin
                    // Reset-entered HOLD leaves pend_done clear, so no O_done.
                    state_d     = ST_IDLE;
                    gen_rst_n_d = 1'b1;
                    done_d      = pend_done_q;
                    pend_done_d = 1'b0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge I_pxl_clk) begin
        if (I_rst) begin
            state_q     <= ST_HOLD;
            hold_cnt_q  <= '0;
            tmo_cnt_q   <= '0;
            for (int unsigned i = 0; i < NREG; i++) begin
                stg_q[i] <= DEF_REGS[i];
                act_q[i] <= DEF_REGS[i];
            end
            stg_pol_q   <= DEF_POL;
            act_pol_q   <= DEF_POL;
            pend_done_q <= 1'b0;
            gen_rst_n_q <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            s_q         <= 1'b0;
            s_d_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            stg_q       <= stg_d;
            act_q       <= act_d;
            stg_pol_q   <= stg_pol_d;
            act_pol_q   <= act_pol_d;
            pend_done_q <= pend_done_d;
            gen_rst_n_q <= gen_rst_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            s_q         <= s_now;
            s_d_q       <= s_q;
        end
    end

    assign O_busy      = busy_q;
    assign O_done      = done_q;
    assign O_err       = err_q;
    assign O_gen_rst_n = gen_rst_n_q;
    assign O_h_total   = act_q[0];
    assign O_h_sync    = act_q[1];
    assign O_h_bporch  = act_q[2];
    assign O_h_res     = act_q[3];
    assign O_v_total   = act_q[4];
    assign O_v_sync    = act_q[5];
    assign O_v_bporch  = act_q[6];
    assign O_v_res     = act_q[7];
    assign O_rd_hres   = act_q[8];
    assign O_rd_vres   = act_q[9];
    assign O_hs_pol    = act_pol_q[0];
    assign O_vs_pol    = act_pol_q[1];

endmodule

// File: tb/tb_vtg_mode_ctrl.sv
// tb_vtg_mode_ctrl
//   Directed bench for vtg_mode_ctrl: reset release, a full 640x480 mode
//   change, a rejected set, writes/commit ignored in WAIT_VS, sync timeout,
//   and reset asserted during HOLD.
module tb_vtg_mode_ctrl;

    logic        clk = 1'b0;
    logic        I_rst;
    logic        I_cfg_wr;
    logic [3:0]  I_cfg_addr;
    logic [15:0] I_cfg_wdata;
    logic        I_commit;
    logic        I_vs;
    logic        O_busy, O_done, O_err;
    logic [15:0] O_h_total, O_h_sync, O_h_bporch, O_h_res;
    logic [15:0] O_v_total, O_v_sync, O_v_bporch, O_v_res;
    logic [15:0] O_rd_hres, O_rd_vres;
    logic        O_hs_pol, O_vs_pol, O_gen_rst_n;

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [15:0] act_out [10];
    logic [15:0] vga     [10];
    logic [15:0] defs    [10];

    always #5 clk = ~clk;

    vtg_mode_ctrl #(.VS_TMO(64)) dut (
        .I_pxl_clk   (clk),
        .I_rst       (I_rst),
        .I_cfg_wr    (I_cfg_wr),
        .I_cfg_addr  (I_cfg_addr),
        .I_cfg_wdata (I_cfg_wdata),
        .I_commit    (I_commit),
        .I_vs        (I_vs),
        .O_busy      (O_busy),
        .O_done      (O_done),
        .O_err       (O_err),
        .O_h_total   (O_h_total),
        .O_h_sync    (O_h_sync),
        .O_h_bporch  (O_h_bporch),
        .O_h_res     (O_h_res),
        .O_v_total   (O_v_total),
        .O_v_sync    (O_v_sync),
        .O_v_bporch  (O_v_bporch),
        .O_v_res     (O_v_res),
        .O_rd_hres   (O_rd_hres),
        .O_rd_vres   (O_rd_vres),
        .O_hs_pol    (O_hs_pol),
        .O_vs_pol    (O_vs_pol),
        .O_gen_rst_n (O_gen_rst_n)
    );

    assign act_out[0] = O_h_total;
    assign act_out[1] = O_h_sync;
    assign act_out[2] = O_h_bporch;
    assign act_out[3] = O_h_res;
    assign act_out[4] = O_v_total;
    assign act_out[5] = O_v_sync;
    assign act_out[6] = O_v_bporch;
    assign act_out[7] = O_v_res;
    assign act_out[8] = O_rd_hres;
    assign act_out[9] = O_rd_vres;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [15:0] d);
        I_cfg_wr    = 1'b1;
        I_cfg_addr  = a;
        I_cfg_wdata = d;
        tick();
        I_cfg_wr    = 1'b0;
    endtask

    task automatic commit();
        I_commit = 1'b1;
        tick();
        I_commit = 1'b0;
    endtask

    initial begin
        vga  = '{16'd800, 16'd96, 16'd48, 16'd640, 16'd525, 16'd2, 16'd33, 16'd480, 16'd640, 16'd480};
        defs = '{16'd1650, 16'd40, 16'd220, 16'd1280, 16'd750, 16'd5, 16'd20, 16'd720, 16'd1280, 16'd720};

        I_rst = 1'b1; I_cfg_wr = 1'b0; I_cfg_addr = '0; I_cfg_wdata = '0;
        I_commit = 1'b0; I_vs = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_gen_rst_n", 32'(O_gen_rst_n), 0);
        check("rst_busy", 32'(O_busy), 1);
        check("rst_done", 32'(O_done), 0);
        check("rst_err", 32'(O_err), 0);
        check("rst_hs_pol", 32'(O_hs_pol), 1);
        check("rst_vs_pol", 32'(O_vs_pol), 1);
        for (int i = 0; i < 10; i++) check($sformatf("rst_act%0d", i), 32'(act_out[i]), 32'(defs[i]));

        // Reset release: generator reset held 4 cycles, no O_done
        I_rst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("rel_gen_rst_n_c%0d", i), 32'(O_gen_rst_n), (i >= 4) ? 1 : 0);
            check($sformatf("rel_done_c%0d", i), 32'(O_done), 0);
        end
        check("rel_busy", 32'(O_busy), 0);

        // 640x480 set, commit, ignored write/commit in WAIT_VS, sync edge
        for (int i = 0; i < 10; i++) cfg_write(4'(i), vga[i]);
        cfg_write(4'd11, 16'd0);
        commit();
        check("vga_busy_check", 32'(O_busy), 1);
        tick();
        check("vga_err", 32'(O_err), 0);
        check("vga_wait_gen_rst_n", 32'(O_gen_rst_n), 1);
        cfg_write(4'd0, 16'd999);
        cfg_write(4'd3, 16'd2000);
        commit();
        check("wait_busy", 32'(O_busy), 1);
        repeat (2) tick();
        check("wait_act_unchanged", 32'(O_h_total), 1650);
        I_vs = 1'b1;
        tick();
        check("vs_e0_h_total", 32'(O_h_total), 1650);
        tick();
        check("vs_e1_h_total", 32'(O_h_total), 1650);
        check("vs_e1_gen_rst_n", 32'(O_gen_rst_n), 1);
        tick();
        for (int i = 0; i < 10; i++) check($sformatf("vga_act%0d", i), 32'(act_out[i]), 32'(vga[i]));
        check("vga_e2_gen_rst_n", 32'(O_gen_rst_n), 0);
        check("vga_e2_done", 32'(O_done), 0);
        for (int i = 3; i <= 5; i++) begin
            tick();
            check($sformatf("vga_hold_e%0d_gen_rst_n", i), 32'(O_gen_rst_n), 0);
            check($sformatf("vga_hold_e%0d_done", i), 32'(O_done), 0);
        end
        tick();
        check("vga_e6_gen_rst_n", 32'(O_gen_rst_n), 1);
        check("vga_e6_done", 32'(O_done), 1);
        check("vga_e6_busy", 32'(O_busy), 0);
        tick();
        check("vga_e7_done", 32'(O_done), 0);
        I_vs = 1'b0;
        tick();

        // Rejected set: 96+48+1700 > 1650
        cfg_write(4'd3, 16'd1700);
        cfg_write(4'd0, 16'd1650);
        commit();
        check("bad_err_c0", 32'(O_err), 0);
        tick();
        check("bad_err_c1", 32'(O_err), 1);
        check("bad_busy", 32'(O_busy), 0);
        check("bad_h_total", 32'(O_h_total), 800);
        check("bad_h_res", 32'(O_h_res), 640);
        check("bad_gen_rst_n", 32'(O_gen_rst_n), 1);
        tick();
        check("bad_err_c2", 32'(O_err), 0);
        check("bad_done", 32'(O_done), 0);

        // Sync timeout: I_vs static, VS_TMO=64
        cfg_write(4'd3, 16'd640);
        cfg_write(4'd0, 16'd900);
        commit();
        for (int k = 1; k <= 70; k++) begin
            tick();
            if (k == 65) check("tmo_k65_h_total", 32'(O_h_total), 800);
            if (k == 66) begin
                check("tmo_k66_h_total", 32'(O_h_total), 900);
                check("tmo_k66_gen_rst_n", 32'(O_gen_rst_n), 0);
            end
            if (k == 69) check("tmo_k69_done", 32'(O_done), 0);
            if (k == 70) begin
                check("tmo_k70_done", 32'(O_done), 1);
                check("tmo_k70_gen_rst_n", 32'(O_gen_rst_n), 1);
            end
        end

        // Reset asserted during HOLD
        cfg_write(4'd0, 16'd1000);
        commit();
        tick();
        I_vs = 1'b1;
        repeat (3) tick();
        check("hr_h_total_applied", 32'(O_h_total), 1000);
        tick();
        I_rst = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) check($sformatf("hr_act%0d", i), 32'(act_out[i]), 32'(defs[i]));
        check("hr_gen_rst_n", 32'(O_gen_rst_n), 0);
        check("hr_busy", 32'(O_busy), 1);
        check("hr_done", 32'(O_done), 0);
        I_rst = 1'b0;
        I_vs  = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("hr_rel_gen_rst_n_c%0d", i), 32'(O_gen_rst_n), (i >= 4) ? 1 : 0);
            check($sformatf("hr_rel_done_c%0d", i), 32'(O_done), 0);
        end

        // Staging was reset to defaults: only v_total differs after apply
        cfg_write(4'd4, 16'd800);
        commit();
        tick();
        I_vs = 1'b1;
        repeat (3) tick();
        check("post_h_total", 32'(O_h_total), 1650);
        check("post_h_res", 32'(O_h_res), 1280);
        check("post_v_total", 32'(O_v_total), 800);
        check("post_gen_rst_n", 32'(O_gen_rst_n), 0);
        repeat (4) tick();
        check("post_done", 32'(O_done), 1);
        I_vs = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
